// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: drives one single-port synchronous RAM as a circular delay
// buffer. Each accepted sample is a read-modify-write at the current pointer:
// the oldest word is returned and the new sample takes its slot. The RAM is
// zeroed after reset and on an explicit clear request.
module delay_line_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_WRITE,
    S_OUT
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] samp_q;

  // Pointer advance with wrap at the buffer length latched for this sample.
  // Using >= rather than == lets a shortened length pull an out-of-range
  // pointer back to 0 on its next advance.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p,
                                                 input logic [ADDR_W-1:0] len);
    return (p >= len) ? '0 : p + 1'b1;
  endfunction

  // Sequencer: all state and the returned sample live in this one register block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_cnt  <= '0;
      ptr      <= '0;
      len_q    <= '0;
      samp_q   <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          ptr     <= '0;
          if (clr_cnt == CLR_LAST) state <= S_IDLE;
        end
        S_IDLE: begin
          if (clear) begin
            clr_cnt <= '0;
            state   <= S_CLEAR;
          end else if (in_valid) begin
            samp_q <= in_data;
            len_q  <= delay_len;
            state  <= S_READ;
          end
        end
        S_READ: begin
          state <= S_WRITE;
        end
        S_WRITE: begin
          // mem_dout still carries the word addressed in READ, i.e. the
          // value being overwritten this cycle.
          out_data <= mem_dout;
          state    <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            ptr   <= next_ptr(ptr, len_q);
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

  // Output decode: RAM strobes and handshakes follow directly from the state.
  always_comb begin
    mem_addr  = ptr;
    mem_we    = 1'b0;
    mem_din   = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_cnt;
      end
      S_IDLE: begin
        in_ready = !clear;
        busy     = 1'b0;
      end
      S_READ: begin
        mem_we = 1'b0;
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        mem_din = samp_q;
      end
      S_OUT: begin
        out_valid = 1'b1;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Sequences a single-port synchronous RAM as a circular delay buffer for the pedal sample path.
- Each accepted input sample is handled as a read-modify-write at the current pointer: the oldest sample is read and returned, and the new sample is written in its place.
- Clears the RAM to zero after reset or on request.
- Sits between the upstream sample source/processor and one RAM instance: 1-cycle registered read latency, write on posedge when we=1.

Parameters:
DATA_W, 8, sample/RAM word width
ADDR_W, 4, RAM address width; RAM depth = 2^ADDR_W

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous reset, active-high
clear  input  1  synchronous request to re-zero RAM and reset pointer
delay_len  input  ADDR_W  buffer length minus one; N = delay_len+1 (1..2^ADDR_W)
in_valid  input  1  input sample valid
in_ready  output  1  controller can accept a sample
in_data  input  DATA_W  input sample
out_valid  output  1  delayed sample valid
out_ready  input  1  downstream accepts delayed sample
out_data  output  DATA_W  delayed sample
mem_addr  output  ADDR_W  RAM address
mem_we  output  1  RAM write enable
mem_din  output  DATA_W  RAM write data
mem_dout  input  DATA_W  RAM read data, valid one cycle after address presented
busy  output  1  high in every state except IDLE

Behaviour:
- FSM states: CLEAR, IDLE, READ, WRITE, OUT. The mem_* outputs, in_ready, out_valid and busy are combinational decodes of state and registers. All other state is registered.
- Async reset: state=CLEAR, clr_cnt=0, ptr=0, len_q=0, samp_q=0, out_data=0. While rst is high: out_valid=0, in_ready=0, busy=1.
- Writes to address 0 with data 0 while in reset are permitted and harmless.
- CLEAR:
  - mem_we=1, mem_addr=clr_cnt, mem_din=0; clr_cnt increments every cycle.
  - After clr_cnt=2^ADDR_W-1 the next state is IDLE, so CLEAR lasts exactly 2^ADDR_W cycles.
  - ptr is forced to 0.
- IDLE:
  - in_ready = !clear; mem_we=0.
  - If clear=1, go to CLEAR with clr_cnt=0. clear wins over a simultaneous in_valid, and that sample is not accepted.
  - Else if in_valid=1: latch samp_q<=in_data and len_q<=delay_len, then go to READ.
  - clear is ignored in all states except IDLE.
- READ: mem_addr=ptr, mem_we=0. Go to WRITE.
- WRITE:
  - mem_addr=ptr, mem_we=1, mem_din=samp_q.
  - out_data<=mem_dout, which is the word read in the READ cycle, i.e. the pre-write value. Go to OUT.
- OUT:
  - out_valid=1, mem_we=0.
  - out_data holds stable while out_ready=0, with no RAM activity.
  - On out_valid&&out_ready: ptr <= (ptr>=len_q) ? 0 : ptr+1, then go to IDLE.
- Latency: in handshake at cycle T → out_valid asserted at T+3. Maximum throughput is one sample per 4 cycles.
- Output relation: with constant delay_len, the k-th output equals the (k-N)-th input, or 0 for k<N, where N=delay_len+1 and k counts from 0 after a clear.
- delay_len change: takes effect at the next accepted sample. If ptr exceeds the new len_q, ptr wraps to 0 at the next advance. No data is discarded except through the length change itself.
- out_data retains its last value after the handshake.
- Reset mid-operation (any state): the in-flight sample is dropped, out_valid drops immediately, and a full CLEAR runs after reset release.

Test Plan:
1. Release rst → 16 cycles of mem_we=1 with mem_addr 0..15 and mem_din=0, busy=1; in_ready=1 in cycle 16; RAM all zero.
2. delay_len=3, out_ready=1, push 0x01..0x08 → out_data sequence 00,00,00,00,01,02,03,04; out_valid exactly 3 cycles after each in handshake.
3. delay_len=0, push 0xAA,0xBB,0xCC → outputs 00,AA,BB; ptr stays 0.
4. delay_len=15, push 0x10..0x23 (20 samples) → outputs 0–15 are 00, outputs 16–19 are 10,11,12,13; ptr wraps 15→0.
5. Backpressure: out_ready=0 for 5 cycles in OUT → out_valid held, out_data stable, in_ready=0, mem_we=0 throughout; release → ptr advances once.
6. clear=1 together with in_valid=1 in IDLE → in_ready=0, 16-cycle CLEAR, sample not accepted. Separately, rst pulsed during OUT → out_valid=0 immediately, then CLEAR, and the next output is 00.
